n64adv_vpll_ctrl: RTL and testbench
===================================

# n64adv_vpll_ctrl

Sequencer for the video PLL and the output video-clock mux in the clock/reset housekeeping. Runs in the system clock domain. Turns the requested line-multiplier mode into a safe order of events: PLL test-enable, lock qualification, PLL use, clock switch. It falls back to native VCLK on lock loss, retries, and reports a sticky failure. It drives `MANAGE_VPLL` and `VCLK_select` of the housekeeping block and reads back its PLL lock flag.

## Interface
- `LOCK_STABLE`, 1024: consecutive synchronized-lock cycles required before the PLL counts as qualified.
- `LOCK_TIMEOUT`, 65535: cycles allowed in `PLL_START` before the attempt counts as a failure.
- `SWITCH_HOLD`, 32: settle cycles between a `MANAGE_VPLL` change and a `VCLK_select` change, in either order.
- `MAX_RETRY`, 3: failed attempts tolerated before entering `FAIL`.
- `SYS_CLK  in  1`: system clock; all logic is on its rising edge.
- `nSRST  in  1`: reset, synchronous, active-low.
- `CFG_LINEMULT  in  2`: requested mode, quasi-static.
  - 00 = bypass; 01 = x2 on VCLK; 1x = x3, which requires the PLL.
- `VCLK_PLL_LOCKED  in  1`: PLL lock flag, asynchronous to `SYS_CLK`.
- `MANAGE_VPLL  out  2`: {USE, TEST}.
- `VCLK_select  out  2`: clock-mux and line-multiplier select.
- `VPLL_BUSY  out  1`: high in every state except `IDLE`, `RUN_PLL` and `FAIL`.
- `VPLL_FAIL  out  1`: high only in `FAIL`.

## Operation
- **Lock synchronizer:** `VCLK_PLL_LOCKED` passes through a 2-FF synchronizer to give `lock_s`. Only `lock_s` is used anywhere in the block.
- **PLL request:** `req_pll = CFG_LINEMULT[1]`.
- **Outputs:** all outputs are registered.
- **Reset values:** `MANAGE_VPLL = 00`, `VCLK_select = 00`, `VPLL_BUSY = 0`, `VPLL_FAIL = 0`. State is `IDLE`; counters and the retry count are 0.
- **Counters:** the counter is 16 bits and is cleared on every state change. The retry count is 2 bits and saturates at `MAX_RETRY`.

States and transitions:
- **`IDLE`**
  - Outputs: `MANAGE_VPLL = 00`; `VCLK_select = {1'b0, CFG_LINEMULT[0]}`, updated every cycle.
  - `req_pll = 1` → `PLL_START`, retry count cleared.
- **`PLL_START`**
  - Outputs: `MANAGE_VPLL = 01`, `VCLK_select = {1'b0, CFG_LINEMULT[0]}`.
  - The stable count increments while `lock_s = 1` and clears when `lock_s = 0`.
  - The timeout count increments every cycle.
  - Stable count reaches `LOCK_STABLE-1` with `lock_s = 1` → `ARM`.
  - Otherwise, timeout count reaches `LOCK_TIMEOUT-1` → retry + 1. Then:
    - retry equals `MAX_RETRY` → `FAIL`;
    - else restart `PLL_START`, with `MANAGE_VPLL = 00` for one cycle to pulse PLL reset.
  - `req_pll = 0` → `IDLE` immediately.
- **`ARM`**
  - Outputs: `MANAGE_VPLL = 10`, `VCLK_select` unchanged.
  - Waits `SWITCH_HOLD` cycles, then → `RUN_PLL`.
  - `lock_s = 0` → `LOSS`.
  - `req_pll = 0` → `DISARM`.
- **`RUN_PLL`**
  - Outputs: `MANAGE_VPLL = 10`, `VCLK_select = 10`.
  - `lock_s = 0` → `LOSS`. This takes priority over `req_pll = 0`.
  - `req_pll = 0` → `DISARM`.
- **`LOSS`**
  - In the same registered update: `VCLK_select = 00` and `MANAGE_VPLL = 01`.
  - Retry + 1. Then:
    - retry reaches `MAX_RETRY` → `FAIL`;
    - else waits `SWITCH_HOLD`, then → `PLL_START`.
- **`DISARM`**
  - Outputs: `VCLK_select = {1'b0, CFG_LINEMULT[0]}`; `MANAGE_VPLL = 10` is held for `SWITCH_HOLD` cycles.
  - Then `MANAGE_VPLL = 00` → `IDLE`.
- **`FAIL`**
  - Outputs: `MANAGE_VPLL = 00`, `VCLK_select = {1'b0, CFG_LINEMULT[0]}`.
  - Sticky while `req_pll = 1`.
  - `req_pll = 0` → `IDLE`, retry count cleared.
- **Invariants:**
  - `VCLK_select[1] = 1` only when `MANAGE_VPLL[1] = 1` and the state is `RUN_PLL`.
  - `MANAGE_VPLL = 11` is never driven.
- **Reset mid-operation:** reset in any state returns to the reset values on the next edge, including from `RUN_PLL`. No hold sequence runs.

## Timing
- `lock_s` follows `VCLK_PLL_LOCKED` by 2 to 3 `SYS_CLK` cycles.
- **Best-case switch latency**, from `req_pll` rising to `VCLK_select = 10`: 1 cycle (`IDLE` → `PLL_START`), then `LOCK_STABLE` cycles after `lock_s` rises, then `SWITCH_HOLD` cycles, then 1 cycle.
- **Lock-loss fallback:** `VCLK_select[1]` falls 1 cycle after `lock_s` falls, which is at most 4 cycles after the raw flag falls.
- **Deselect:** `VCLK_select[1]` falls 1 cycle after `req_pll` falls. `MANAGE_VPLL[1]` falls `SWITCH_HOLD` cycles later.
- **Glitches:** a lock glitch of exactly 1 `lock_s` cycle in `PLL_START` restarts the stable count; it does not count as a retry.
- **`CFG_LINEMULT` changes between 00 and 01** in `IDLE` appear on `VCLK_select[0]` after 1 cycle.

## Test plan
- **Lock and switch:** reset, `CFG_LINEMULT = 10`, assert lock 100 cycles later (parameters 16/1000/8/3). Expect `MANAGE_VPLL = 01`, then `10` once 16 stable cycles have been seen, and `VCLK_select = 10` exactly 8 cycles after that. `VPLL_BUSY = 0` in `RUN_PLL`.
- **Lock loss and recovery:** in `RUN_PLL`, drop lock. Expect `VCLK_select = 00` and `MANAGE_VPLL = 01` at most 4 cycles later. Reassert lock and expect a return to `RUN_PLL`.
- **Timeout to FAIL:** `CFG_LINEMULT = 10`, lock never asserted. Expect 3 timeouts of 1000 cycles, with a 1-cycle `MANAGE_VPLL = 00` pulse between attempts. Then `VPLL_FAIL = 1` and `MANAGE_VPLL = 00`. Set `CFG_LINEMULT = 01` and expect `IDLE` with `VCLK_select = 01`.
- **Deselect:** in `RUN_PLL`, set `CFG_LINEMULT = 00`. Expect `VCLK_select = 00` next cycle, `MANAGE_VPLL = 10` for 8 cycles, then `00`.
- **Simultaneous events:** in `RUN_PLL`, drop lock and the request in the same cycle. Expect `LOSS` (retry = 1), then `PLL_START`, then `IDLE`. `VCLK_select[1] = 1` must never coincide with `MANAGE_VPLL[1] = 0`.
- **Mid-operation reset:** pull `nSRST` low in `ARM`. Expect all outputs at reset values on the next edge.

Source files
------------

// File: rtl/n64adv_vpll_ctrl.sv
// Video PLL sequencer: orders PLL test/use and the VCLK mux switch,
// falls back to native VCLK on lock loss, retries, and flags failure.
//
// Ports:
//   SYS_CLK          system clock, rising edge
//   nSRST            synchronous active-low reset
//   CFG_LINEMULT     requested mode (00 bypass, 01 x2, 1x x3 via PLL)
//   VCLK_PLL_LOCKED  raw PLL lock flag, asynchronous to SYS_CLK
//   MANAGE_VPLL      {USE, TEST} to the housekeeping block
//   VCLK_select      clock-mux / line-multiplier select
//   VPLL_BUSY        sequence in progress
//   VPLL_FAIL        sticky failure, cleared by dropping the PLL request
module n64adv_vpll_ctrl #(
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int SWITCH_HOLD  = 32,
  parameter int MAX_RETRY    = 3
) (
  input  logic       SYS_CLK,
  input  logic       nSRST,
  input  logic [1:0] CFG_LINEMULT,
  input  logic       VCLK_PLL_LOCKED,
  output logic [1:0] MANAGE_VPLL,
  output logic [1:0] VCLK_select,
  output logic       VPLL_BUSY,
  output logic       VPLL_FAIL
);

  localparam logic [15:0] STABLE_END  = 16'(LOCK_STABLE - 1);
  localparam logic [15:0] TIMEOUT_END = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] HOLD_END    = 16'(SWITCH_HOLD - 1);
  localparam logic [1:0]  RETRY_MAX   = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RESTART,
    S_ARM,
    S_RUN,
    S_LOSS,
    S_DISARM,
    S_FAIL
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [15:0] tcnt;
  logic [15:0] scnt;
  logic [15:0] tcnt_nxt;
  logic [15:0] scnt_nxt;
  logic [1:0]  retry;
  logic [1:0]  retry_nxt;
  logic [1:0]  retry_inc;
  logic        lock_m;
  logic        lock_s;
  logic        req_pll;
  logic [1:0]  mv_nxt;
  logic [1:0]  vs_nxt;
  logic        busy_nxt;
  logic        fail_nxt;

  assign req_pll   = CFG_LINEMULT[1];
  assign retry_inc = (retry == RETRY_MAX) ? retry : retry + 2'd1;

  always_comb begin
    nxt       = state;
    retry_nxt = retry;
    tcnt_nxt  = tcnt + 16'd1;
    scnt_nxt  = lock_s ? scnt + 16'd1 : 16'd0;
    case (state)
      S_IDLE: begin
        if (req_pll) begin
          nxt       = S_START;
          retry_nxt = 2'd0;
        end
      end
      S_START: begin
        if (!req_pll) begin
          nxt = S_IDLE;
        end else if (lock_s && scnt == STABLE_END) begin
          nxt = S_ARM;
        end else if (tcnt == TIMEOUT_END) begin
          retry_nxt = retry_inc;
          nxt = (retry_inc == RETRY_MAX) ? S_FAIL : S_RESTART;
        end
      end
      // one cycle with TEST low pulses the PLL reset
      S_RESTART: nxt = S_START;
      S_ARM: begin
        if (!lock_s) begin
          nxt       = S_LOSS;
          retry_nxt = retry_inc;
        end else if (!req_pll) begin
          nxt = S_DISARM;
        end else if (tcnt == HOLD_END) begin
          nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          nxt       = S_LOSS;
          retry_nxt = retry_inc;
        end else if (!req_pll) begin
          nxt = S_DISARM;
        end
      end
      S_LOSS: begin
        if (retry == RETRY_MAX) begin
          nxt = S_FAIL;
        end else if (tcnt == HOLD_END) begin
          nxt = S_START;
        end
      end
      S_DISARM: begin
        if (tcnt == HOLD_END) begin
          nxt = S_IDLE;
        end
      end
      S_FAIL: begin
        if (!req_pll) begin
          nxt       = S_IDLE;
          retry_nxt = 2'd0;
        end
      end
      default: nxt = S_IDLE;
    endcase
    if (nxt != state) begin
      tcnt_nxt = 16'd0;
      scnt_nxt = 16'd0;
    end
  end

  // outputs are decoded from the next state so they change on the
  // same edge as the state itself
  always_comb begin
    mv_nxt = 2'b00;
    vs_nxt = {1'b0, CFG_LINEMULT[0]};
    case (nxt)
      S_START:  mv_nxt = 2'b01;
      S_ARM: begin
        mv_nxt = 2'b10;
        vs_nxt = VCLK_select;
      end
      S_RUN: begin
        mv_nxt = 2'b10;
        vs_nxt = 2'b10;
      end
      S_LOSS: begin
        mv_nxt = 2'b01;
        vs_nxt = 2'b00;
      end
      S_DISARM: mv_nxt = 2'b10;
      default:  mv_nxt = 2'b00;
    endcase
    busy_nxt = !(nxt inside {S_IDLE, S_RUN, S_FAIL});
    fail_nxt = (nxt == S_FAIL);
  end

  always_ff @(posedge SYS_CLK) begin
    if (!nSRST) begin
      state       <= S_IDLE;
      tcnt        <= 16'd0;
      scnt        <= 16'd0;
      retry       <= 2'd0;
      lock_m      <= 1'b0;
      lock_s      <= 1'b0;
      MANAGE_VPLL <= 2'b00;
      VCLK_select <= 2'b00;
      VPLL_BUSY   <= 1'b0;
      VPLL_FAIL   <= 1'b0;
    end else begin
      state       <= nxt;
      tcnt        <= tcnt_nxt;
      scnt        <= scnt_nxt;
      retry       <= retry_nxt;
      lock_m      <= VCLK_PLL_LOCKED;
      lock_s      <= lock_m;
      MANAGE_VPLL <= mv_nxt;
      VCLK_select <= vs_nxt;
      VPLL_BUSY   <= busy_nxt;
      VPLL_FAIL   <= fail_nxt;
    end
  end

endmodule

// File: tb/tb_n64adv_vpll_ctrl.sv
// Scoreboard bench for n64adv_vpll_ctrl: a timestamp-based mode model
// predicts every registered output; a monitor compares each cycle.
module tb_n64adv_vpll_ctrl;

  localparam int LS = 16;
  localparam int LT = 1000;
  localparam int SH = 8;
  localparam int MR = 3;

  logic       SYS_CLK = 1'b0;
  logic       nSRST = 1'b0;
  logic [1:0] CFG_LINEMULT = 2'b00;
  logic       VCLK_PLL_LOCKED = 1'b0;
  logic [1:0] MANAGE_VPLL;
  logic [1:0] VCLK_select;
  logic       VPLL_BUSY;
  logic       VPLL_FAIL;

  n64adv_vpll_ctrl #(
    .LOCK_STABLE (LS),
    .LOCK_TIMEOUT(LT),
    .SWITCH_HOLD (SH),
    .MAX_RETRY   (MR)
  ) dut (
    .SYS_CLK        (SYS_CLK),
    .nSRST          (nSRST),
    .CFG_LINEMULT   (CFG_LINEMULT),
    .VCLK_PLL_LOCKED(VCLK_PLL_LOCKED),
    .MANAGE_VPLL    (MANAGE_VPLL),
    .VCLK_select    (VCLK_select),
    .VPLL_BUSY      (VPLL_BUSY),
    .VPLL_FAIL      (VPLL_FAIL)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  typedef struct packed {
    logic [1:0] mv;
    logic [1:0] vs;
    logic       busy;
    logic       fail;
  } exp_t;

  typedef enum {
    M_OFF, M_WAIT, M_PULSE, M_ARM,
    M_ON, M_LOST, M_DOWN, M_DEAD
  } mode_t;

  exp_t  expq[$];
  int    n_checks = 0;
  int    n_pass = 0;

  mode_t md = M_OFF;
  int    cyc = 0;
  int    ent = 0;
  int    run = 0;
  int    tries = 0;
  logic  d1 = 1'b0;
  logic  d2 = 1'b0;
  exp_t  e = '0;

  task automatic check(string name, logic [5:0] act, logic [5:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t",
                  name, act, want, $time);
  endtask

  function automatic int bump(int t);
    return (t < MR) ? t + 1 : MR;
  endfunction

  // Predicts the outputs after the coming clock edge from the inputs
  // currently applied.  Elapsed time in a mode is cyc - ent.
  task automatic model_step();
    logic       ls;
    logic       req;
    logic [1:0] lo;
    mode_t      nm;
    cyc++;
    if (!nSRST) begin
      md = M_OFF; ent = cyc; run = 0; tries = 0;
      d1 = 1'b0; d2 = 1'b0; e = '0;
    end else begin
      ls = d2; d2 = d1; d1 = VCLK_PLL_LOCKED;
      req = CFG_LINEMULT[1];
      lo = {1'b0, CFG_LINEMULT[0]};
      nm = md;
      case (md)
        M_OFF: if (req) begin nm = M_WAIT; tries = 0; end
        M_WAIT: begin
          if (!req) nm = M_OFF;
          else begin
            run = ls ? run + 1 : 0;
            if (run == LS) nm = M_ARM;
            else if (cyc - ent == LT) begin
              tries = bump(tries);
              nm = (tries == MR) ? M_DEAD : M_PULSE;
            end
          end
        end
        M_PULSE: nm = M_WAIT;
        M_ARM: begin
          if (!ls) begin nm = M_LOST; tries = bump(tries); end
          else if (!req) nm = M_DOWN;
          else if (cyc - ent == SH) nm = M_ON;
        end
        M_ON: begin
          if (!ls) begin nm = M_LOST; tries = bump(tries); end
          else if (!req) nm = M_DOWN;
        end
        M_LOST: begin
          if (tries == MR) nm = M_DEAD;
          else if (cyc - ent == SH) nm = M_WAIT;
        end
        M_DOWN: if (cyc - ent == SH) nm = M_OFF;
        M_DEAD: if (!req) begin nm = M_OFF; tries = 0; end
        default: nm = M_OFF;
      endcase
      if (nm != md) begin ent = cyc; run = 0; end
      md = nm;
      case (md)
        M_WAIT:  begin e.mv = 2'b01; e.vs = lo;    end
        M_ARM:   begin e.mv = 2'b10;               end
        M_ON:    begin e.mv = 2'b10; e.vs = 2'b10; end
        M_LOST:  begin e.mv = 2'b01; e.vs = 2'b00; end
        M_DOWN:  begin e.mv = 2'b10; e.vs = lo;    end
        default: begin e.mv = 2'b00; e.vs = lo;    end
      endcase
      e.busy = !(md inside {M_OFF, M_ON, M_DEAD});
      e.fail = (md == M_DEAD);
    end
  endtask

  task automatic tick();
    model_step();
    expq.push_back(e);
    @(negedge SYS_CLK);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  always begin
    exp_t x;
    @(posedge SYS_CLK);
    #1;
    if (expq.size() > 0) begin
      x = expq.pop_front();
      check("outputs",
            {MANAGE_VPLL, VCLK_select, VPLL_BUSY, VPLL_FAIL}, x);
      check("mv_not_11", {5'b0, MANAGE_VPLL == 2'b11}, 6'd0);
      check("sel_needs_use",
            {5'b0, VCLK_select[1] && MANAGE_VPLL != 2'b10}, 6'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    bit hit;
    int lock_left;
    @(negedge SYS_CLK);
    nSRST = 1'b0; ticks(4);
    nSRST = 1'b1; ticks(5);

    // lock and switch
    CFG_LINEMULT = 2'b10; ticks(100);
    VCLK_PLL_LOCKED = 1'b1; ticks(60);

    // lock loss and recovery
    VCLK_PLL_LOCKED = 1'b0; ticks($urandom_range(3, 20));
    VCLK_PLL_LOCKED = 1'b1; ticks(70);

    // deselect
    CFG_LINEMULT = 2'b00; ticks(20);

    // lock_s and req_pll fall on the same edge
    CFG_LINEMULT = 2'b10; ticks(60);
    VCLK_PLL_LOCKED = 1'b0; ticks(2);
    CFG_LINEMULT = 2'b00; ticks(30);

    // timeout to FAIL, then leave via a non-PLL mode
    CFG_LINEMULT = 2'($urandom_range(2, 3));
    ticks(3 * (LT + 1) + 20);
    CFG_LINEMULT = 2'b01; ticks(5);
    CFG_LINEMULT = 2'b00; ticks(3);

    // reset while arming
    VCLK_PLL_LOCKED = 1'b1;
    CFG_LINEMULT = 2'b10;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick();
      hit = (md == M_ARM);
    end
    n_checks++;
    if (hit) n_pass++;
    else $display("FAIL reach_arm: got timeout expected ARM");
    nSRST = 1'b0; tick();
    nSRST = 1'b1; ticks(5);

    // random mix of mode changes, lock chatter, glitches and resets
    lock_left = 0;
    for (int i = 0; i < 2500; i++) begin
      if (lock_left == 0) begin
        VCLK_PLL_LOCKED = ~VCLK_PLL_LOCKED;
        lock_left = ($urandom_range(0, 1) == 0) ?
                    $urandom_range(1, 3) : $urandom_range(20, 400);
      end
      lock_left--;
      if ($urandom_range(0, 199) == 0)
        CFG_LINEMULT = 2'($urandom_range(0, 3));
      nSRST = ($urandom_range(0, 799) != 0);
      tick();
    end
    nSRST = 1'b1;
    CFG_LINEMULT = 2'b00;
    VCLK_PLL_LOCKED = 1'b0;
    ticks(20);

    repeat (2) @(posedge SYS_CLK);
    #2;
    n_checks++;
    if (expq.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", expq.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
